// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the FIFO pointer blocks:
//   PTR_W(size)            - pointer width for a 2^size-deep FIFO (one wrap bit)
//   af_level_default(size) - default almost-full threshold, 2^size - 2
//   bin2gray / gray2bin    - code conversions.
// The conversions work at any width up to 32 bits. Zero-extend the argument
// to 32 bits and cast the result back to the pointer width. The leading zeros
// do not change the low bits of either conversion.
// -----------------------------------------------------------------------------
package fifo_pkg;

   function automatic int PTR_W(input int size);
      return size + 1;
   endfunction

   function automatic int af_level_default(input int size);
      return (1 << size) - 2;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin[31] = gray[31];
      for (int i = 30; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_wr_ptr_if.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr_if
// Producer handshake and pointer-exchange bundle of the FIFO write side.
//   wr_en       - producer write request
//   rd_gray_ptr - read pointer (Gray), from the read clock domain
//   wr_addr     - binary RAM write address
//   wr_accept   - RAM write strobe
//   wr_gray_ptr - registered Gray write pointer toward the read side
//   full        - registered full flag
//   almost_full - registered almost-full flag (only with FIFO_ALMOST_FULL_EN)
// Modports: master = producer / environment, slave = fifo_wr_ptr.
// Optional feature macro: FIFO_ALMOST_FULL_EN.
// -----------------------------------------------------------------------------
interface fifo_wr_ptr_if #(
   parameter int SIZE = 4
);
   logic            wr_en;
   logic [SIZE:0]   rd_gray_ptr;
   logic [SIZE-1:0] wr_addr;
   logic            wr_accept;
   logic [SIZE:0]   wr_gray_ptr;
   logic            full;
`ifdef FIFO_ALMOST_FULL_EN
   logic            almost_full;

   modport master (
      output wr_en, rd_gray_ptr,
      input  wr_addr, wr_accept, wr_gray_ptr, full, almost_full
   );
   modport slave (
      input  wr_en, rd_gray_ptr,
      output wr_addr, wr_accept, wr_gray_ptr, full, almost_full
   );
`else
   modport master (
      output wr_en, rd_gray_ptr,
      input  wr_addr, wr_accept, wr_gray_ptr, full
   );
   modport slave (
      input  wr_en, rd_gray_ptr,
      output wr_addr, wr_accept, wr_gray_ptr, full
   );
`endif
endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a WIDTH-bit bus. Use it only for buses that change
// at most one bit at a time, such as Gray pointers. This keeps any sampled
// value either the old word or the new word.
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both stages to 0
//   d   - asynchronous input
//   q   - synchronized output, two edges after d
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;
endmodule

// File: rtl/fifo_wr_ptr.sv
// -----------------------------------------------------------------------------
// fifo_wr_ptr
// Write-side pointer and full-flag generator for an asynchronous FIFO.
// The block counts accepted writes in binary and supplies the RAM write
// address. It publishes a registered Gray write pointer to the read side.
// It compares the next Gray pointer with the synchronized read pointer and
// registers the result as 'full', so 'full' rises on the same edge as the
// write that fills the FIFO.
//   clk, rst - clock and asynchronous active-high reset
//   wif      - fifo_wr_ptr_if.slave: wr_en, rd_gray_ptr in; wr_addr,
//              wr_accept, wr_gray_ptr, full (and almost_full) out
// Optional feature macro: FIFO_ALMOST_FULL_EN adds the registered
// 'almost_full' flag, which is set when occupancy >= AF_LEVEL.
// -----------------------------------------------------------------------------
module fifo_wr_ptr
   import fifo_pkg::*;
#(
   parameter int SIZE     = 4,
   parameter int AF_LEVEL = af_level_default(SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   fifo_wr_ptr_if.slave  wif
);
   localparam int W = PTR_W(SIZE);

   // Reject illegal parameter values at elaboration.
   if (SIZE < 2) begin : g_bad_size
      $error("fifo_wr_ptr: SIZE must be >= 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > (1 << SIZE)) begin : g_bad_af_level
      $error("fifo_wr_ptr: AF_LEVEL must be in 1..2**SIZE");
   end

   logic [W-1:0] wbin_reg;
   logic [W-1:0] wbin_next;
   logic [W-1:0] wgray_next;
   logic [W-1:0] wr_gray_reg;
   logic [W-1:0] rq2;
   logic [W-1:0] full_gray;
   logic         full_reg;
   logic         wr_accept;

   sync_2ff #(.WIDTH(W)) u_rd_sync (
      .clk (clk),
      .rst (rst),
      .d   (wif.rd_gray_ptr),
      .q   (rq2)
   );

   assign wr_accept  = wif.wr_en & ~full_reg;
   assign wbin_next  = wbin_reg + W'(wr_accept);
   assign wgray_next = W'(bin2gray(32'(wbin_next)));

   // The write pointer is exactly one lap (2^SIZE) ahead of the read pointer.
   // In Gray code this means the top two bits are inverted and the rest are equal.
   assign full_gray = {~rq2[W-1:W-2], rq2[W-3:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbin_reg    <= '0;
         wr_gray_reg <= '0;
         full_reg    <= 1'b0;
      end else begin
         wbin_reg    <= wbin_next;
         wr_gray_reg <= wgray_next;
         full_reg    <= (wgray_next == full_gray);
      end
   end

   assign wif.wr_addr     = wbin_reg[SIZE-1:0];
   assign wif.wr_accept   = wr_accept;
   assign wif.wr_gray_ptr = wr_gray_reg;
   assign wif.full        = full_reg;

`ifdef FIFO_ALMOST_FULL_EN
   logic [W-1:0] rbin_s;
   logic [W-1:0] fill;
   logic         almost_full_reg;

   // Occupancy as the write side sees it. The read pointer here is stale, so
   // the value is high or exact, and the flag can only be late to clear.
   assign rbin_s = W'(gray2bin(32'(rq2)));
   assign fill   = wbin_next - rbin_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         almost_full_reg <= 1'b0;
      end else begin
         almost_full_reg <= (fill >= W'(AF_LEVEL));
      end
   end

   assign wif.almost_full = almost_full_reg;
`endif
endmodule

// File: tb/tb_fifo_wr_ptr.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ptr
// Self-checking bench for fifo_wr_ptr with SIZE = 4 (depth 16).
// The reference model counts accepted writes as an integer. It keeps the read
// count the bench drives, delayed by two edges, and derives full and
// almost_full from occupancy = (writes - synchronized reads) mod 32.
// Define FIFO_ALMOST_FULL_EN to also exercise almost_full (AF_LEVEL 14).
// -----------------------------------------------------------------------------
module tb_fifo_wr_ptr;
   localparam int SIZE  = 4;
   localparam int DEPTH = 16;
   localparam int AF    = 14;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_ptr_if #(.SIZE(SIZE)) bus ();

   fifo_wr_ptr #(.SIZE(SIZE)) dut (
      .clk (clk),
      .rst (rst),
      .wif (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state.
   int wcnt;       // accepted writes, mod 32
   int rd_cnt;     // read count currently driven, mod 32
   int rd_q[$];    // read counts sampled on previous edges (2-edge delay)
   bit full_exp;
   bit af_exp;
   bit wen_drv;

   function automatic logic [4:0] gray(input int n);
      logic [4:0] b;
      b = n[4:0];
      return b ^ (b >> 1);
   endfunction

   function automatic int occ(input int w, input int r);
      return (w - r) & 31;
   endfunction

   task automatic drive(input bit wen, input int rc);
      wen_drv         = wen;
      rd_cnt          = rc & 31;
      bus.wr_en       = wen;
      bus.rd_gray_ptr = gray(rd_cnt);
      #1;
   endtask

   // One rising edge, plus the matching update of the reference model.
   task automatic edge_step();
      bit acc;
      int used;
      acc = wen_drv && !full_exp;
      @(posedge clk);
      if (acc) wcnt = (wcnt + 1) & 31;
      used = rd_q.pop_front();
      rd_q.push_back(rd_cnt);
      full_exp = (occ(wcnt, used) == DEPTH);
      af_exp   = (occ(wcnt, used) >= AF);
      #1;
   endtask

   task automatic do_reset();
      rst             = 1'b1;
      bus.wr_en       = 1'b0;
      bus.rd_gray_ptr = '0;
      wen_drv         = 1'b0;
      rd_cnt          = 0;
      wcnt            = 0;
      rd_q            = {0, 0};
      full_exp        = 1'b0;
      af_exp          = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({bus.wr_addr, bus.wr_gray_ptr, bus.full} !== 10'b0) begin
         failures++;
         $display("FAIL reset_state: addr/gray/full got %h/%b/%b, need 0/00000/0",
                  bus.wr_addr, bus.wr_gray_ptr, bus.full);
      end
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 0);
         edge_step();
      end
      checks++;
      if (bus.wr_addr !== 4'd7 || bus.wr_gray_ptr !== gray(7)) begin
         failures++;
         $display("FAIL pre_reset_7: addr/gray got %0d/%b, need 7/%b",
                  bus.wr_addr, bus.wr_gray_ptr, gray(7));
      end
      // Assert reset between edges; the outputs must clear without a clock edge.
      rst = 1'b1;
      #1;
      checks++;
      if ({bus.wr_addr, bus.wr_gray_ptr, bus.full} !== 10'b0) begin
         failures++;
         $display("FAIL async_reset: addr/gray/full got %h/%b/%b, need 0/00000/0",
                  bus.wr_addr, bus.wr_gray_ptr, bus.full);
      end
      do_reset();
      drive(1'b1, 0);
      edge_step();
      checks++;
      if (bus.wr_addr !== 4'd1 || bus.wr_gray_ptr !== 5'b00001) begin
         failures++;
         $display("FAIL first_write: addr/gray got %0d/%b, need 1/00001",
                  bus.wr_addr, bus.wr_gray_ptr);
      end
      $display("test_reset done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1'b1, 0);
         checks++;
         if (bus.wr_accept !== 1'b1) begin
            failures++;
            $display("FAIL fill_accept[%0d]: got %b, need 1", i, bus.wr_accept);
         end
         edge_step();
         checks++;
         if ({bus.wr_addr, bus.wr_gray_ptr, bus.full} !==
             {wcnt[3:0], gray(wcnt), full_exp}) begin
            failures++;
            $display("FAIL fill_step[%0d]: addr/gray/full got %0d/%b/%b, need %0d/%b/%b",
                     i, bus.wr_addr, bus.wr_gray_ptr, bus.full,
                     wcnt[3:0], gray(wcnt), full_exp);
         end
      end
      checks++;
      if (bus.full !== 1'b1 || bus.wr_gray_ptr !== 5'b11000) begin
         failures++;
         $display("FAIL fill_full16: full/gray got %b/%b, need 1/11000",
                  bus.full, bus.wr_gray_ptr);
      end
      drive(1'b1, 0);
      checks++;
      if (bus.wr_accept !== 1'b0) begin
         failures++;
         $display("FAIL drop_accept: got %b, need 0", bus.wr_accept);
      end
      edge_step();
      checks++;
      if (bus.wr_gray_ptr !== 5'b11000 || bus.wr_addr !== 4'd0 || bus.full !== 1'b1) begin
         failures++;
         $display("FAIL drop_hold: gray/addr/full got %b/%0d/%b, need 11000/0/1",
                  bus.wr_gray_ptr, bus.wr_addr, bus.full);
      end
      $display("test_fill done: checks=%0d failures=%0d", checks, failures);
   endtask

   // Continues from the full state left by test_fill.
   task automatic test_release();
      bit exp_full [3];
      exp_full = '{1'b1, 1'b1, 1'b0};
      for (int e = 0; e < 3; e++) begin
         drive(1'b0, 1);
         edge_step();
         checks++;
         if (bus.full !== exp_full[e]) begin
            failures++;
            $display("FAIL release_edge%0d: full got %b, need %b", e + 1, bus.full, exp_full[e]);
         end
      end
      drive(1'b1, 1);
      checks++;
      if (bus.wr_accept !== 1'b1 || bus.wr_addr !== 4'd0) begin
         failures++;
         $display("FAIL release_write: accept/addr got %b/%0d, need 1/0",
                  bus.wr_accept, bus.wr_addr);
      end
      edge_step();
      $display("test_release done: checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_wrap_random();
      int          writes;
      bit          wrap_seen;
      bit          wen;
      int          rc;
      logic [4:0]  prev_gray;
      do_reset();
      writes    = 0;
      wrap_seen = 1'b0;
      prev_gray = bus.wr_gray_ptr;
      for (int c = 0; c < 400; c++) begin
         wen = ($urandom_range(0, 3) != 0);
         rc  = rd_cnt;
         if (occ(wcnt, rd_cnt) > 0 && $urandom_range(0, 1) == 1) rc = rd_cnt + 1;
         drive(wen, rc);
         checks++;
         if (bus.wr_accept !== (wen && !full_exp)) begin
            failures++;
            $display("FAIL rand_accept[%0d]: got %b, need %b", c, bus.wr_accept, wen && !full_exp);
         end
         if (wen && !full_exp) writes++;
         edge_step();
         checks++;
         if ({bus.wr_addr, bus.wr_gray_ptr, bus.full} !==
             {wcnt[3:0], gray(wcnt), full_exp}) begin
            failures++;
            $display("FAIL rand_state[%0d]: addr/gray/full got %0d/%b/%b, need %0d/%b/%b",
                     c, bus.wr_addr, bus.wr_gray_ptr, bus.full,
                     wcnt[3:0], gray(wcnt), full_exp);
         end
`ifdef FIFO_ALMOST_FULL_EN
         checks++;
         if (bus.almost_full !== af_exp) begin
            failures++;
            $display("FAIL rand_af[%0d]: got %b, need %b", c, bus.almost_full, af_exp);
         end
`endif
         if (prev_gray == 5'b10000 && bus.wr_gray_ptr == 5'b00000) wrap_seen = 1'b1;
         prev_gray = bus.wr_gray_ptr;
      end
      checks++;
      if (!wrap_seen || writes < 40) begin
         failures++;
         $display("FAIL wrap: wrap_seen=%b writes=%0d, need 1 and >=40", wrap_seen, writes);
      end
      $display("test_wrap_random done: writes=%0d checks=%0d failures=%0d", writes, checks, failures);
   endtask

   task automatic test_simultaneous();
      bit exp_acc  [4];
      bit exp_full [3];
      exp_acc  = '{1'b1, 1'b0, 1'b0, 1'b1};
      exp_full = '{1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 15; i++) begin
         drive(1'b1, 0);
         edge_step();
      end
      for (int e = 0; e < 3; e++) begin
         drive(1'b1, 1);
         checks++;
         if (bus.wr_accept !== exp_acc[e]) begin
            failures++;
            $display("FAIL simul_accept%0d: got %b, need %b", e, bus.wr_accept, exp_acc[e]);
         end
         edge_step();
         checks++;
         if (bus.full !== exp_full[e]) begin
            failures++;
            $display("FAIL simul_full%0d: got %b, need %b", e, bus.full, exp_full[e]);
         end
      end
      drive(1'b1, 1);
      checks++;
      if (bus.wr_accept !== exp_acc[3] || bus.wr_addr !== 4'd0 || bus.wr_gray_ptr !== 5'b11000) begin
         failures++;
         $display("FAIL simul_after: accept/addr/gray got %b/%0d/%b, need 1/0/11000",
                  bus.wr_accept, bus.wr_addr, bus.wr_gray_ptr);
      end
      edge_step();
      $display("test_simultaneous done: checks=%0d failures=%0d", checks, failures);
   endtask

`ifdef FIFO_ALMOST_FULL_EN
   task automatic test_almost_full();
      bit exp_af [3];
      exp_af = '{1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 1; i <= 14; i++) begin
         drive(1'b1, 0);
         edge_step();
         checks++;
         if (bus.almost_full !== (i >= 14)) begin
            failures++;
            $display("FAIL af_write%0d: got %b, need %b", i, bus.almost_full, i >= 14);
         end
      end
      for (int e = 0; e < 3; e++) begin
         drive(1'b0, 1);
         edge_step();
         checks++;
         if (bus.almost_full !== exp_af[e]) begin
            failures++;
            $display("FAIL af_release%0d: got %b, need %b", e + 1, bus.almost_full, exp_af[e]);
         end
      end
      $display("test_almost_full done: checks=%0d failures=%0d", checks, failures);
   endtask
`endif

   initial begin
      bus.wr_en       = 1'b0;
      bus.rd_gray_ptr = '0;
      test_reset();
      test_fill();
      test_release();
      test_wrap_random();
      test_simultaneous();
`ifdef FIFO_ALMOST_FULL_EN
      test_almost_full();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
